// File: rtl/xpb_table_gen.sv
// xpb_table_gen: fills a 2^DIGIT_BITS-entry table with entry[k] = k*B mod M.
// Each entry is built from the previous one by a limb-serial modular add:
// sum = acc + B and diff = sum - M are formed LIMB bits per cycle, and one of
// them is selected as the new accumulator and written out.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         generation request, sampled only while idle
//   base_in_i       reduction base B (B < M), latched on start
//   modulus_i       modulus M (M > 0), latched on start
//   busy_o          high while a run is in progress
//   done_o          one-cycle pulse after the last entry is written
//   wr_en_o         table write strobe, one cycle per entry
//   wr_addr_o       table index k
//   wr_data_o       entry value k*B mod M
module xpb_table_gen #(
    parameter int unsigned WIDTH      = 1024,
    parameter int unsigned LIMB       = 64,
    parameter int unsigned DIGIT_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      base_in_i,
    input  logic [WIDTH-1:0]      modulus_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  wr_en_o,
    output logic [DIGIT_BITS-1:0] wr_addr_o,
    output logic [WIDTH-1:0]      wr_data_o
);

    localparam int unsigned NLIMBS = WIDTH / LIMB;
    localparam int unsigned LCW    = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
    localparam logic [LCW-1:0]        LAST_LIMB = LCW'(NLIMBS - 1);
    localparam logic [DIGIT_BITS-1:0] LAST_K    = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ZERO  = 3'd1,
        S_CALC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      b_q, b_d;
    logic [WIDTH-1:0]      m_q, m_d;
    logic [WIDTH-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]      sum_q, sum_d;
    logic [WIDTH-1:0]      diff_q, diff_d;
    logic [DIGIT_BITS-1:0] k_q, k_d;
    logic [LCW-1:0]        limb_q, limb_d;
    logic                  carry_q, carry_d;
    logic                  borrow_q, borrow_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wr_en_q, wr_en_d;
    logic [DIGIT_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]      wr_data_q, wr_data_d;

    // Limb-serial add/subtract slice for the current limb
    logic [LIMB-1:0]  acc_limb, b_limb, m_limb;
    logic [LIMB:0]    sum_ext, diff_ext;
    logic [WIDTH-1:0] entry_sel;

    assign acc_limb = LIMB'(acc_q >> (32'(limb_q) * LIMB));
    assign b_limb   = LIMB'(b_q   >> (32'(limb_q) * LIMB));
    assign m_limb   = LIMB'(m_q   >> (32'(limb_q) * LIMB));

    assign sum_ext  = {1'b0, acc_limb} + {1'b0, b_limb} + (LIMB+1)'(carry_q);
    // MSB of the (LIMB+1)-bit difference is the borrow out
    assign diff_ext = {1'b0, sum_ext[LIMB-1:0]} - {1'b0, m_limb} - (LIMB+1)'(borrow_q);

    // A carry out of bit WIDTH means sum >= 2^WIDTH > M, so subtract regardless of borrow
    assign entry_sel = (carry_q || !borrow_q) ? diff_q : sum_q;

    // State register and datapath/output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            b_q       <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
            diff_q    <= '0;
            k_q       <= '0;
            limb_q    <= '0;
            carry_q   <= 1'b0;
            borrow_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            diff_q    <= diff_d;
            k_q       <= k_d;
            limb_q    <= limb_d;
            carry_q   <= carry_d;
            borrow_q  <= borrow_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_ZERO;
            S_ZERO:  state_d = S_CALC;
            S_CALC:  if (limb_q == LAST_LIMB) state_d = S_WRITE;
            S_WRITE: state_d = (k_q == LAST_K) ? S_DONE : S_CALC;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        b_d      = b_q;
        m_d      = m_q;
        acc_d    = acc_q;
        sum_d    = sum_q;
        diff_d   = diff_q;
        k_d      = k_q;
        limb_d   = limb_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    b_d   = base_in_i;
                    m_d   = modulus_i;
                    acc_d = '0;
                    k_d   = '0;
                end
            end
            S_ZERO: begin
                k_d      = DIGIT_BITS'(1);
                limb_d   = '0;
                carry_d  = 1'b0;
                borrow_d = 1'b0;
            end
            S_CALC: begin
                // Shift each finished limb in from the top; after NLIMBS cycles LSB limb lands at bit 0
                sum_d    = WIDTH'({sum_ext[LIMB-1:0], sum_q} >> LIMB);
                diff_d   = WIDTH'({diff_ext[LIMB-1:0], diff_q} >> LIMB);
                carry_d  = sum_ext[LIMB];
                borrow_d = diff_ext[LIMB];
                limb_d   = limb_q + LCW'(1);
            end
            S_WRITE: begin
                acc_d = entry_sel;
                if (k_q != LAST_K) begin
                    k_d      = k_q + DIGIT_BITS'(1);
                    limb_d   = '0;
                    carry_d  = 1'b0;
                    borrow_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Registered output values
    always_comb begin
        busy_d    = 1'b0;
        done_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            S_ZERO: begin
                busy_d    = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = '0;
                wr_data_d = '0;
            end
            S_CALC: busy_d = 1'b1;
            S_WRITE: begin
                busy_d    = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = k_q;
                wr_data_d = entry_sel;
            end
            S_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Testbench for xpb_table_gen: default 1024/64 instance plus a 128/32 variant.
// Expected entries come from a wide-arithmetic model (k*B) % M.
module tb_xpb_table_gen;

    localparam int W   = 1024;
    localparam int L   = 64;
    localparam int D   = 5;
    localparam int NE  = 32;
    localparam int PER = W / L + 1;
    localparam int WS   = 128;
    localparam int LS   = 32;
    localparam int PERS = WS / LS + 1;

    typedef logic [W+7:0] wide_t;

    logic clk = 1'b0;
    logic rst_n;

    logic          start_i;
    logic [W-1:0]  base_in_i, modulus_i;
    logic          busy_o, done_o, wr_en_o;
    logic [D-1:0]  wr_addr_o;
    logic [W-1:0]  wr_data_o;

    logic          start_s;
    logic [WS-1:0] base_s, mod_s;
    logic          busy_s, done_s, wr_en_s;
    logic [D-1:0]  wr_addr_s;
    logic [WS-1:0] wr_data_s;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] got [NE];

    always #5 clk = ~clk;

    xpb_table_gen #(.WIDTH(W), .LIMB(L), .DIGIT_BITS(D)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .base_in_i(base_in_i), .modulus_i(modulus_i),
        .busy_o(busy_o), .done_o(done_o), .wr_en_o(wr_en_o),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
    );

    xpb_table_gen #(.WIDTH(WS), .LIMB(LS), .DIGIT_BITS(D)) dut_s (
        .clk(clk), .rst_n(rst_n), .start_i(start_s),
        .base_in_i(base_s), .modulus_i(mod_s),
        .busy_o(busy_s), .done_o(done_s), .wr_en_o(wr_en_s),
        .wr_addr_o(wr_addr_s), .wr_data_o(wr_data_s)
    );

    // Reference: table entry straight from the definition
    function automatic logic [W-1:0] ref_entry(input int unsigned k, input logic [W-1:0] b,
                                               input logic [W-1:0] m);
        wide_t p;
        p = wide_t'(b) * wide_t'(k);
        return W'(p % wide_t'(m));
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // One full run on the default instance; optional extra start pulses at cycles pa/pb
    task automatic run_default(input logic [W-1:0] b, input logic [W-1:0] m,
                               input int pa, input int pb, input string tag);
        int nwr;
        int ndone;
        int k;
        logic exp_wr;
        logic exp_busy;
        logic [W-1:0] ed;
        nwr   = 0;
        ndone = 0;
        @(negedge clk);
        base_in_i = b;
        modulus_i = m;
        start_i   = 1'b1;
        @(negedge clk);
        start_i   = 1'b0;
        base_in_i = rand_wide();
        modulus_i = rand_wide();
        checks++;
        if (busy_o !== 1'b0 || wr_en_o !== 1'b0) begin
            errors++;
            $display("FAIL %s cycle0: busy=%b wr_en=%b expected 0/0", tag, busy_o, wr_en_o);
        end
        for (int c = 1; c <= 535; c++) begin
            @(negedge clk);
            exp_wr   = ((c - 1) % PER == 0) && ((c - 1) / PER < NE);
            exp_busy = (c <= 1 + (NE - 1) * PER);
            checks++;
            if (wr_en_o !== exp_wr) begin
                errors++;
                $display("FAIL %s wr_en c=%0d: got %b expected %b", tag, c, wr_en_o, exp_wr);
            end
            if (wr_en_o === 1'b1) nwr++;
            if (exp_wr) begin
                k  = (c - 1) / PER;
                ed = ref_entry(k, b, m);
                got[k] = wr_data_o;
                checks++;
                if (wr_addr_o !== D'(k)) begin
                    errors++;
                    $display("FAIL %s wr_addr c=%0d: got %0d expected %0d", tag, c, wr_addr_o, k);
                end
                checks++;
                if (wr_data_o !== ed) begin
                    errors++;
                    $display("FAIL %s wr_data k=%0d (low 128b): got %h expected %h",
                             tag, k, wr_data_o[127:0], ed[127:0]);
                end
            end
            checks++;
            if (busy_o !== exp_busy) begin
                errors++;
                $display("FAIL %s busy c=%0d: got %b expected %b", tag, c, busy_o, exp_busy);
            end
            checks++;
            if (done_o !== (c == 2 + (NE - 1) * PER)) begin
                errors++;
                $display("FAIL %s done c=%0d: got %b expected %b", tag, c, done_o,
                         (c == 2 + (NE - 1) * PER));
            end
            if (done_o === 1'b1) ndone++;
            start_i   = (c == pa) || (c == pb);
            base_in_i = rand_wide();
            modulus_i = rand_wide();
        end
        start_i = 1'b0;
        checks++;
        if (nwr != NE) begin
            errors++;
            $display("FAIL %s write_count: got %0d expected %0d", tag, nwr, NE);
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL %s done_count: got %0d expected 1", tag, ndone);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start_i   = 1'b0;
        base_in_i = '0;
        modulus_i = W'(1);
        start_s   = 1'b0;
        base_s    = '0;
        mod_s     = WS'(1);
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_o, done_o, wr_en_o} !== 3'b000 || wr_addr_o !== '0 || wr_data_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy/done/wr_en=%b%b%b addr=%0d expected all 0",
                     busy_o, done_o, wr_en_o, wr_addr_o);
        end
        checks++;
        if ({busy_s, done_s, wr_en_s} !== 3'b000 || wr_addr_s !== '0 || wr_data_s !== '0) begin
            errors++;
            $display("FAIL reset_outputs_small: busy/done/wr_en=%b%b%b expected all 0",
                     busy_s, done_s, wr_en_s);
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (wr_en_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet: wr_en=%b busy=%b expected 0/0", wr_en_o, busy_o);
            end
        end
    endtask

    task automatic test_small_modulus();
        run_default(W'(97), W'(40) == 0 ? W'(1) : W'(97), 0, 0, "small");
    endtask

    task automatic test_small_values();
        logic [W-1:0] b;
        logic [W-1:0] m;
        b = W'(40);
        m = W'(97);
        run_default(b, m, 0, 0, "small40");
        checks++;
        if (got[0] !== W'(0))  begin errors++; $display("FAIL small_e0: got %0d expected 0",  got[0][31:0]); end
        checks++;
        if (got[1] !== W'(40)) begin errors++; $display("FAIL small_e1: got %0d expected 40", got[1][31:0]); end
        checks++;
        if (got[3] !== W'(23)) begin errors++; $display("FAIL small_e3: got %0d expected 23", got[3][31:0]); end
        checks++;
        if (got[31] !== W'(76)) begin errors++; $display("FAIL small_e31: got %0d expected 76", got[31][31:0]); end
    endtask

    task automatic test_full_carry();
        logic [W-1:0] m;
        logic [W-1:0] e31;
        m   = '1;
        e31 = '0;
        e31 = e31 - W'(32);
        run_default(m - W'(1), m, 0, 0, "carry");
        checks++;
        if (got[31] !== e31) begin
            errors++;
            $display("FAIL carry_e31 (low 128b): got %h expected %h", got[31][127:0], e31[127:0]);
        end
        checks++;
        if (got[1] !== m - W'(1)) begin
            errors++;
            $display("FAIL carry_e1 (low 128b): got %h expected %h", got[1][127:0], (m - W'(1)));
        end
    endtask

    task automatic test_random_moduli();
        logic [W-1:0] m;
        logic [W-1:0] b;
        for (int it = 0; it < 2; it++) begin
            m = rand_wide();
            m[W-1] = 1'b1;
            m[0]   = 1'b1;
            if (it == 0) b = W'((wide_t'(1) << 320) % wide_t'(m));
            else         b = W'(wide_t'(rand_wide()) % wide_t'(m));
            run_default(b, m, 0, 0, (it == 0) ? "prod_2p320" : "rand_base");
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] m;
        m = rand_wide();
        m[W-1] = 1'b1;
        run_default(W'(wide_t'(rand_wide()) % wide_t'(m)), m, 100, 300, "busy_start");
    endtask

    task automatic test_midrun_reset();
        logic [W-1:0] m;
        m = rand_wide();
        m[W-2] = 1'b1;
        @(negedge clk);
        base_in_i = W'(wide_t'(rand_wide()) % wide_t'(m));
        modulus_i = m;
        start_i   = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, wr_en_o} !== 3'b000 || wr_addr_o !== '0 || wr_data_o !== '0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: busy/done/wr_en=%b%b%b addr=%0d expected all 0",
                     busy_o, done_o, wr_en_o, wr_addr_o);
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if (wr_en_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_quiet c=%0d: wr_en=%b busy=%b expected 0/0",
                         c, wr_en_o, busy_o);
            end
        end
        run_default(W'(wide_t'(rand_wide()) % wide_t'(m)), m, 0, 0, "after_reset");
    endtask

    task automatic test_param_variant();
        int nwr;
        int k;
        logic exp_wr;
        logic [WS-1:0] ed;
        logic [WS-1:0] last;
        nwr = 0;
        @(negedge clk);
        base_s  = WS'(40);
        mod_s   = WS'(97);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        base_s  = WS'($urandom());
        mod_s   = WS'($urandom());
        for (int c = 1; c <= 162; c++) begin
            @(negedge clk);
            exp_wr = ((c - 1) % PERS == 0) && ((c - 1) / PERS < NE);
            checks++;
            if (wr_en_s !== exp_wr) begin
                errors++;
                $display("FAIL var wr_en c=%0d: got %b expected %b", c, wr_en_s, exp_wr);
            end
            if (wr_en_s === 1'b1) nwr++;
            if (exp_wr) begin
                k  = (c - 1) / PERS;
                ed = WS'(ref_entry(k, W'(40), W'(97)));
                if (k == NE - 1) last = wr_data_s;
                checks++;
                if (wr_addr_s !== D'(k) || wr_data_s !== ed) begin
                    errors++;
                    $display("FAIL var entry k=%0d: got addr %0d data %0d expected addr %0d data %0d",
                             k, wr_addr_s, wr_data_s, k, ed);
                end
            end
            checks++;
            if (done_s !== (c == 2 + (NE - 1) * PERS)) begin
                errors++;
                $display("FAIL var done c=%0d: got %b expected %b", c, done_s,
                         (c == 2 + (NE - 1) * PERS));
            end
            checks++;
            if (busy_s !== (c <= 1 + (NE - 1) * PERS)) begin
                errors++;
                $display("FAIL var busy c=%0d: got %b expected %b", c, busy_s,
                         (c <= 1 + (NE - 1) * PERS));
            end
        end
        checks++;
        if (last !== WS'(76)) begin
            errors++;
            $display("FAIL var_e31: got %0d expected 76", last);
        end
        checks++;
        if (nwr != NE) begin
            errors++;
            $display("FAIL var write_count: got %0d expected %0d", nwr, NE);
        end
    endtask

    initial begin
        test_reset();
        test_small_values();
        test_full_carry();
        test_random_moduli();
        test_back_to_back();
        test_midrun_reset();
        test_param_variant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xpb_table_gen.md
# xpb_table_gen

Runtime generator for the 32-entry precomputed-multiple tables used by the modular-square reduction stage. The tables hold entry[k] = k·B mod M for k = 0..31, where B is a reduction base such as 2^320 mod M. This block fills the table for an arbitrary modulus instead of relying on synthesized constants. It walks k upward with limb-serial modular additions and writes each entry through a simple RAM write port that the table lookup side reads.

## Interface
- WIDTH, 1024: operand/entry width in bits; must be an integer multiple of LIMB.
- LIMB, 64: bits processed per cycle in the serial add/subtract datapath.
- DIGIT_BITS, 5: table index width; the table holds 2^DIGIT_BITS entries.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  generation request; sampled only in IDLE.
- base_in  in  WIDTH  reduction base B; requires B < M.
- modulus  in  WIDTH  modulus M; requires M > 0.
- busy  out  1  high while a generation run is in progress.
- done  out  1  one-cycle pulse after the final entry is written.
- wr_en  out  1  table write strobe, one cycle per entry.
- wr_addr  out  DIGIT_BITS  table index k.
- wr_data  out  WIDTH  entry value k·B mod M.

## Operation
- The FSM has five states: IDLE, ZERO, CALC, WRITE and DONE.
- IDLE: when start=1, the block latches base_in and modulus into internal registers and clears acc and k, then goes to ZERO.
  - Changes on base_in or modulus after the start edge are ignored.
- ZERO: issues the write for entry 0 (wr_data=0) and sets k=1.
  - It also clears the limb counter and the carry/borrow flags, then goes to CALC.
- CALC: runs WIDTH/LIMB cycles, processing limb i in cycle i, LSB limb first.
  - sum_i = acc_i + B_i + carry, which updates carry.
  - diff_i = sum_i − M_i − borrow, which updates borrow.
  - sum_i and diff_i are stored into the sum and diff shadow registers.
  - After the final limb the block goes to WRITE.
- WRITE: selects diff if (final carry=1) or (final borrow=0); otherwise it selects sum.
  - The selected value is loaded into acc and driven on wr_data with wr_addr=k and wr_en=1.
  - If k = 2^DIGIT_BITS−1, the next state is DONE. Otherwise k increments, the limb counter and flags clear, and the next state is CALC.
- DONE: pulses done for one cycle and returns to IDLE.
- Arithmetic: because acc < M and B < M, the sum is below 2M and at most one conditional subtraction is needed.
  - The carry out of bit WIDTH is part of the comparison and must not be dropped.
  - If B ≥ M, the same single-subtract rule still applies, but the results are unspecified.
- start asserted while busy=1 is ignored; it is not queued.
- Reset, asynchronous at any time including mid-run:
  - Every output goes to 0 and the FSM goes to IDLE.
  - No further writes occur, and entries already written are not rolled back.

## Timing
- Let cycle 0 be the cycle in which start=1 is sampled in IDLE.
- wr_en, wr_addr, wr_data, busy and done are registered outputs.
- Write schedule:
  - Entry 0 is written in cycle 1.
  - Entry k is written in cycle 1 + k·(WIDTH/LIMB + 1).
  - With default parameters: 17 cycles per entry, entry 31 written in cycle 528, done=1 in cycle 529.
- busy is 1 from cycle 1 through the last write cycle inclusive, and 0 in the done cycle.
- wr_data and wr_addr hold their last written value between strokes. They are meaningful only when wr_en=1.
- A new start is accepted no earlier than cycle 530 with default parameters, i.e. the first IDLE cycle after done.

## Test plan
- Small modulus, WIDTH=1024, M=97, B=40 → 32 writes at addresses 0..31 with data k·40 mod 97.
  - Check entry 0=0, entry 1=40, entry 3=23, entry 31=76.
  - Check done in cycle 529 and busy low in that cycle.
- Full-width carry case, M = 2^1024−1, B = M−1 → entry k = M−k for k ≥ 1; entry 31 = 2^1024−32.
  - The WIDTH-bit carry out is exercised on every step.
- Production set: M is the VDF modulus and B = 2^320 mod M → all 32 entries bit-match the golden-model k·B mod M constants.
- Busy-start: pulse start at cycles 100 and 300 during a run → write schedule unchanged, exactly 32 writes, a single done pulse.
- Mid-run reset: assert rst_n=0 at cycle 200.
  - All outputs go to 0 immediately and no wr_en follows.
  - A new start after release gives a fresh run whose entry 0 appears in cycle 1 relative to the new start.
- Parameter variant WIDTH=128, LIMB=32, M=97, B=40 → 5 cycles per entry; entry 31 (value 76) written in cycle 156, done in cycle 157.
